// File: rtl/vga_console_pkg.sv
// rtl/vga_console_pkg.sv - shared constants, state enum and cursor helpers for the console master
package vga_console_pkg;

  // Controller register byte offsets
  localparam logic [7:0] REG_CTRL       = 8'h00;
  localparam logic [7:0] REG_STATUS     = 8'h04;
  localparam logic [7:0] REG_POS        = 8'h08;
  localparam logic [7:0] REG_ASCII      = 8'h0C;
  localparam logic [7:0] REG_CHAR_COLOR = 8'h10;
  localparam logic [7:0] REG_BG_COLOR   = 8'h14;

  // CTRL command bits
  localparam logic [31:0] CTRL_DRAW = 32'h0000_0001;
  localparam logic [31:0] CTRL_FILL = 32'h0000_0002;

  // Character codes with special handling
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TILDE = 8'h7E;

  // Text grid geometry
  localparam int COLS = 40;
  localparam int ROWS = 30;
  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [3:0] {
    ST_INIT_CC,
    ST_INIT_BG,
    ST_CLR_POLL,
    ST_CLR_WR,
    ST_IDLE,
    ST_POLL,
    ST_WR_POS,
    ST_WR_ASC,
    ST_WR_CTL,
    ST_ADV
  } state_t;

  // Row after a line feed or wrap; the screen never scrolls
  function automatic logic [4:0] next_row(input logic [4:0] row);
    return (row == LAST_ROW) ? 5'd0 : row + 5'd1;
  endfunction

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= ASCII_SPACE) && (c <= ASCII_TILDE);
  endfunction

  // POS register layout: row in [12:8], column in [5:0]
  function automatic logic [31:0] pos_word(input logic [4:0] row, input logic [5:0] col);
    return {19'd0, row, 2'b00, col};
  endfunction

endpackage

// File: rtl/console_char_fifo.sv
// rtl/console_char_fifo.sv - first-word-fall-through character FIFO with registered full flag
module console_char_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  input  logic          pop,
  output logic [DW-1:0] rd_data,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_next;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_next = count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
  end

  // Pointers, occupancy and the registered full flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (PW+1)'(DEPTH));
    end
  end

  // Storage array needs no reset; occupancy guards every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/vga_console_master.sv
// rtl/vga_console_master.sv - character stream to VGA controller register-write sequencer
module vga_console_master
  import vga_console_pkg::*;
#(
  parameter int          AW         = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [23:0] CHAR_RGB   = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB     = 24'h000000
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          ch_valid_i,
  input  logic [7:0]    ch_data_i,
  output logic          ch_ready_o,
  input  logic          clear_i,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic [AW-1:0] wbm_adr_o,
  output logic [31:0]   wbm_dat_o,
  output logic [3:0]    wbm_sel_o,
  input  logic [31:0]   wbm_dat_i,
  input  logic          wbm_ack_i,
  input  logic          wbm_err_i,
  output logic [4:0]    cursor_row_o,
  output logic [5:0]    cursor_col_o,
  output logic          busy_o,
  output logic          err_o
);

  state_t        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [4:0]    row_q, row_d;
  logic [5:0]    col_q, col_d;
  logic [7:0]    char_q, char_d;
  logic          adv_q, adv_d;
  logic          err_q, err_d;
  logic          clr_q, clr_d;

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [7:0]    fifo_data;

  logic          is_bus;
  logic          req_we;
  logic [7:0]    req_off;
  logic [31:0]   req_dat;
  logic          done;
  logic          status_busy;
  logic          absorb_clear;
  logic          unused_dat;

  assign unused_dat  = ^wbm_dat_i[31:1];
  assign status_busy = wbm_dat_i[0];

  console_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (8)
  ) u_fifo (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .push    (ch_valid_i),
    .wr_data (ch_data_i),
    .full    (fifo_full),
    .pop     (fifo_pop),
    .rd_data (fifo_data),
    .empty   (fifo_empty)
  );

  // Register access issued by each bus-owning state
  always_comb begin
    is_bus  = 1'b1;
    req_we  = 1'b1;
    req_off = REG_STATUS;
    req_dat = '0;
    case (state_q)
      ST_INIT_CC: begin
        req_off = REG_CHAR_COLOR;
        req_dat = {8'h00, CHAR_RGB};
      end
      ST_INIT_BG: begin
        req_off = REG_BG_COLOR;
        req_dat = {8'h00, BG_RGB};
      end
      ST_CLR_POLL, ST_POLL: req_we = 1'b0;
      ST_CLR_WR: begin
        req_off = REG_CTRL;
        req_dat = CTRL_FILL;
      end
      ST_WR_POS: begin
        req_off = REG_POS;
        req_dat = pos_word(row_q, col_q);
      end
      ST_WR_ASC: begin
        req_off = REG_ASCII;
        req_dat = {24'h0, char_q};
      end
      ST_WR_CTL: begin
        req_off = REG_CTRL;
        req_dat = CTRL_DRAW;
      end
      default: begin
        is_bus = 1'b0;
        req_we = 1'b0;
      end
    endcase
  end

  // A clear arriving while the screen is already being cleared adds nothing
  assign absorb_clear = (state_q == ST_INIT_CC) || (state_q == ST_INIT_BG) ||
                        (state_q == ST_CLR_POLL) || (state_q == ST_CLR_WR) ||
                        ((state_q == ST_IDLE) && clr_q);

  // Next-state, bus cycle and cursor logic
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    row_d    = row_q;
    col_d    = col_q;
    char_d   = char_q;
    adv_d    = adv_q;
    err_d    = err_q;
    clr_d    = clr_q;
    fifo_pop = 1'b0;
    done     = 1'b0;

    // Start a cycle only from cyc=0, which guarantees an idle gap between cycles
    if (is_bus) begin
      if (!cyc_q) begin
        cyc_d = 1'b1;
        we_d  = req_we;
        adr_d = AW'(req_off);
        dat_d = req_dat;
      end else if (wbm_err_i || wbm_ack_i) begin
        cyc_d = 1'b0;
        we_d  = 1'b0;
        adr_d = '0;
        dat_d = '0;
        if (wbm_err_i) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          done = 1'b1;
        end
      end
    end

    case (state_q)
      ST_INIT_CC:  if (done) state_d = ST_INIT_BG;
      ST_INIT_BG:  if (done) state_d = ST_CLR_POLL;
      ST_CLR_POLL: if (done && !status_busy) state_d = ST_CLR_WR;
      ST_CLR_WR: begin
        if (done) begin
          row_d   = '0;
          col_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (clr_q) begin
          clr_d   = 1'b0;
          state_d = ST_CLR_POLL;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (is_printable(fifo_data)) begin
            char_d  = fifo_data;
            adv_d   = 1'b1;
            state_d = ST_POLL;
          end else if (fifo_data == ASCII_LF) begin
            col_d = '0;
            row_d = next_row(row_q);
          end else if (fifo_data == ASCII_CR) begin
            col_d = '0;
          end else if ((fifo_data == ASCII_BS) && (col_q != '0)) begin
            col_d   = col_q - 6'd1;
            char_d  = ASCII_SPACE;
            adv_d   = 1'b0;
            state_d = ST_POLL;
          end
        end
      end
      ST_POLL:   if (done && !status_busy) state_d = ST_WR_POS;
      ST_WR_POS: if (done) state_d = ST_WR_ASC;
      ST_WR_ASC: if (done) state_d = ST_WR_CTL;
      ST_WR_CTL: if (done) state_d = adv_q ? ST_ADV : ST_IDLE;
      ST_ADV: begin
        if (col_q == LAST_COL) begin
          col_d = '0;
          row_d = next_row(row_q);
        end else begin
          col_d = col_q + 6'd1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (clear_i && !absorb_clear) clr_d = 1'b1;
  end

  // State, bus and cursor registers; reset drops the bus cycle immediately
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_INIT_CC;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      char_q  <= '0;
      adv_q   <= 1'b0;
      err_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      row_q   <= row_d;
      col_q   <= col_d;
      char_q  <= char_d;
      adv_q   <= adv_d;
      err_q   <= err_d;
      clr_q   <= clr_d;
    end
  end

  assign wbm_cyc_o    = cyc_q;
  assign wbm_stb_o    = cyc_q;
  assign wbm_we_o     = we_q;
  assign wbm_adr_o    = adr_q;
  assign wbm_dat_o    = dat_q;
  assign wbm_sel_o    = cyc_q ? 4'hF : 4'h0;
  assign cursor_row_o = row_q;
  assign cursor_col_o = col_q;
  assign err_o        = err_q;
  assign ch_ready_o   = !fifo_full;
  assign busy_o       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_vga_console_master.sv
// tb/tb_vga_console_master.sv - self-checking bench for vga_console_master
module tb_vga_console_master;

  localparam int AW = 8;

  typedef struct packed {
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ch_valid = 1'b0;
  logic [7:0]    ch_data = 8'h00;
  logic          ch_ready;
  logic          clear = 1'b0;
  logic          cyc, stb, we;
  logic [AW-1:0] adr;
  logic [31:0]   dat_o;
  logic [3:0]    sel;
  logic [31:0]   dat_i = 32'h0;
  logic          ack = 1'b0;
  logic          err = 1'b0;
  logic [4:0]    row;
  logic [5:0]    col;
  logic          busy;
  logic          err_flag;

  txn_t log_mem [4096];
  int   log_n = 0;
  int   log_base = 0;
  txn_t exp_q [$];
  int   mode = 0;          // 0 ack, 1 never respond, 2 err on ASCII write
  bit   rand_lat = 1'b0;
  int   status_reads = 0;
  int   busy_until = 0;
  int   wait_cnt = 0;
  int   total = 0;
  int   bad = 0;
  int   p = 0;             // model cursor as linear cell index

  always #5 clk = ~clk;

  vga_console_master #(.AW(AW)) dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .ch_valid_i   (ch_valid),
    .ch_data_i    (ch_data),
    .ch_ready_o   (ch_ready),
    .clear_i      (clear),
    .wbm_cyc_o    (cyc),
    .wbm_stb_o    (stb),
    .wbm_we_o     (we),
    .wbm_adr_o    (adr),
    .wbm_dat_o    (dat_o),
    .wbm_sel_o    (sel),
    .wbm_dat_i    (dat_i),
    .wbm_ack_i    (ack),
    .wbm_err_i    (err),
    .cursor_row_o (row),
    .cursor_col_o (col),
    .busy_o       (busy),
    .err_o        (err_flag)
  );

  // Slave model: logs each terminated cycle, STATUS busy while status_reads < busy_until
  always @(posedge clk) begin
    ack <= 1'b0;
    err <= 1'b0;
    if (cyc && stb && !ack && !err && mode != 1) begin
      if (wait_cnt > 0) begin
        wait_cnt <= wait_cnt - 1;
      end else begin
        if (log_n < 4096) log_mem[log_n] <= '{we, adr, (we ? dat_o : 32'h0), sel};
        log_n <= log_n + 1;
        if (!we && adr == 8'h04) begin
          dat_i <= {31'h0, (status_reads < busy_until)};
          status_reads <= status_reads + 1;
        end
        if (mode == 2 && we && adr == 8'h0C) err <= 1'b1;
        else ack <= 1'b1;
        wait_cnt <= rand_lat ? int'($urandom_range(0, 2)) : 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic txn_t wr(input logic [7:0] a, input logic [31:0] d);
    return '{1'b1, a, d, 4'hF};
  endfunction

  function automatic txn_t rd_status();
    return '{1'b0, 8'h04, 32'h0, 4'hF};
  endfunction

  task automatic exp_render(input int r, input int c, input logic [7:0] ch, input int polls);
    repeat (polls) exp_q.push_back(rd_status());
    exp_q.push_back(wr(8'h08, 32'(r * 256 + c)));
    exp_q.push_back(wr(8'h0C, {24'h0, ch}));
    exp_q.push_back(wr(8'h00, 32'h1));
  endtask

  // Reference behaviour of one character, on a linear 40x30 cursor
  task automatic model_char(input logic [7:0] c, input int polls);
    if (c >= 8'h20 && c <= 8'h7E) begin
      exp_render(p / 40, p % 40, c, polls);
      p = (p + 1) % 1200;
    end else if (c == 8'h0A) begin
      p = (((p / 40) + 1) % 30) * 40;
    end else if (c == 8'h0D) begin
      p = (p / 40) * 40;
    end else if (c == 8'h08) begin
      if (p % 40 != 0) begin
        p = p - 1;
        exp_render(p / 40, p % 40, 8'h20, polls);
      end
    end
  endtask

  task automatic exp_clear();
    exp_q.push_back(rd_status());
    exp_q.push_back(wr(8'h00, 32'h2));
    p = 0;
  endtask

  task automatic exp_init();
    exp_q.push_back(wr(8'h10, 32'h00FF_FFFF));
    exp_q.push_back(wr(8'h14, 32'h0000_0000));
    exp_clear();
  endtask

  task automatic compare_log(input string tag);
    int n;
    n = log_n - log_base;
    check({tag, " txn count"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check({tag, " txn"}, 64'(log_mem[log_base + i]), 64'(exp_q[i]));
    log_base = log_n;
    exp_q.delete();
  endtask

  task automatic check_cursor(input string tag);
    check({tag, " row"}, 64'(row), 64'(p / 40));
    check({tag, " col"}, 64'(col), 64'(p % 40));
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check({tag, " idle"}, 64'(busy), 64'(0));
  endtask

  task automatic push(input logic [7:0] c);
    for (int i = 0; i < 3000 && !ch_ready; i++) @(negedge clk);
    ch_valid = 1'b1;
    ch_data  = c;
    @(negedge clk);
    ch_valid = 1'b0;
  endtask

  task automatic push_model(input logic [7:0] c);
    push(c);
    model_char(c, 1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    exp_clear();
  endtask

  function automatic logic [7:0] rand_print();
    return 8'($urandom_range(32, 126));
  endfunction

  initial begin
    logic [7:0] c;
    int acc;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst cyc", 64'(cyc), 0);
    check("rst stb", 64'(stb), 0);
    check("rst we", 64'(we), 0);
    check("rst adr", 64'(adr), 0);
    check("rst dat", 64'(dat_o), 0);
    check("rst sel", 64'(sel), 0);
    check("rst row", 64'(row), 0);
    check("rst col", 64'(col), 0);
    check("rst err", 64'(err_flag), 0);
    check("rst ready", 64'(ch_ready), 1);
    check("rst busy", 64'(busy), 1);
    rst_n = 1'b1;

    // Init sequence
    wait_idle("init");
    exp_init();
    compare_log("init");
    check_cursor("init");

    // First printable
    push_model(8'h41);
    wait_idle("A");
    compare_log("A");
    check_cursor("A");
    check("A col const", 64'(col), 1);

    // Busy status for three polls
    busy_until = status_reads + 3;
    push(8'h42);
    model_char(8'h42, 4);
    wait_idle("poll");
    compare_log("poll");
    check_cursor("poll");

    // Wrap from the last cell
    do_clear();
    for (int i = 0; i < 29; i++) push_model(8'h0A);
    for (int i = 0; i < 39; i++) push_model(rand_print());
    wait_idle("fill");
    compare_log("fill");
    check_cursor("at 29,39");
    push_model(8'h5A);
    wait_idle("wrap");
    check("wrap pos word", 64'(log_mem[log_base + 1].dat), 64'h1D27);
    compare_log("wrap");
    check("wrap row", 64'(row), 0);
    check("wrap col", 64'(col), 0);
    for (int i = 0; i < 5; i++) push_model(8'h0A);
    for (int i = 0; i < 10; i++) push_model(rand_print());
    wait_idle("to 5,10");
    compare_log("to 5,10");
    push_model(8'h0A);
    wait_idle("lf");
    compare_log("lf");
    check("lf row", 64'(row), 6);
    check("lf col", 64'(col), 0);

    // Backspace at column 0 and mid-row
    do_clear();
    for (int i = 0; i < 3; i++) push_model(8'h0A);
    wait_idle("to 3,0");
    compare_log("to 3,0");
    push_model(8'h08);
    wait_idle("bs col0");
    compare_log("bs col0");
    check_cursor("bs col0");
    for (int i = 0; i < 5; i++) push_model(rand_print());
    wait_idle("to 3,5");
    compare_log("to 3,5");
    push_model(8'h08);
    wait_idle("bs");
    check("bs pos word", 64'(log_mem[log_base + 1].dat), 64'h0304);
    compare_log("bs");
    check("bs row", 64'(row), 3);
    check("bs col", 64'(col), 4);

    // Random burst with random slave latency
    rand_lat = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: c = 8'h0A;
        1: c = 8'h0D;
        2: c = 8'h08;
        3: c = 8'($urandom_range(0, 255));
        default: c = rand_print();
      endcase
      push_model(c);
    end
    wait_idle("burst");
    compare_log("burst");
    check_cursor("burst");
    rand_lat = 1'b0;
    @(negedge clk);

    // Stalled slave: FIFO fills, then reset mid-cycle
    mode = 1;
    push(8'h51);
    repeat (4) @(negedge clk);
    check("stall cyc", 64'(cyc), 1);
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      ch_valid = 1'b1;
      ch_data  = 8'(8'h61 + i);
      if (ch_ready) acc++;
      @(negedge clk);
    end
    ch_valid = 1'b0;
    check("fifo accepted", 64'(acc), 16);
    check("fifo ready", 64'(ch_ready), 0);
    check("fifo busy", 64'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("async cyc", 64'(cyc), 0);
    check("async stb", 64'(stb), 0);
    check("async ready", 64'(ch_ready), 1);
    mode = 0;
    repeat (2) @(negedge clk);
    log_base = log_n;
    exp_q.delete();
    rst_n = 1'b1;
    wait_idle("reinit");
    exp_init();
    compare_log("reinit");
    check_cursor("reinit");
    check("reinit err", 64'(err_flag), 0);

    // Bus error on the ASCII write
    mode = 2;
    push(8'h45);
    wait_idle("err");
    exp_q.push_back(rd_status());
    exp_q.push_back(wr(8'h08, 32'h0));
    exp_q.push_back(wr(8'h0C, 32'h45));
    compare_log("err");
    check("err flag", 64'(err_flag), 1);
    check_cursor("err");
    mode = 0;
    push_model(8'h46);
    wait_idle("after err");
    compare_log("after err");
    check_cursor("after err");
    check("err sticky", 64'(err_flag), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
